data_ram: RTL and testbench
===========================

Name: data_ram

Overview:
- Word-addressed data memory for the RV32I 5-stage pipeline; serves the MEM stage for load/store instructions.
- Synchronous write on the clock's rising edge when `store` is high.
- Combinational read gated by `load`.
- Asynchronous active-low reset clears the whole array.

Parameters:
- ADDR_WIDTH, 12, word-address width; depth = 2**ADDR_WIDTH = 4096 words.
- DATA_WIDTH, 32, word width in bits.

Ports:
- clk  input  1  system clock; all writes on rising edge.
- rst_n  input  1  reset, asynchronous, active-low; clears memory contents.
- data_memory_address  input  ADDR_WIDTH  word address (not byte address), 0..4095.
- data_memory_data_in  input  DATA_WIDTH  write data.
- store  input  1  write enable; active-high.
- load  input  1  read enable; active-high.
- data_memory_data_out  output  DATA_WIDTH  read data.

Behaviour:
- One clock domain. Reset is asynchronous and active-low. No handshake and no state machine.
- Storage: DEPTH x DATA_WIDTH array, indexed directly by data_memory_address. No byte enables; only full-word writes.
- Reset:
  - rst_n low forces every word to 0 immediately, independent of clk.
  - While rst_n is low, writes are ignored and data_memory_data_out = 0.
  - Reset deassertion is sampled at the next rising edge.
  - Reset mid-operation discards any in-flight write. Contents are all zero afterwards.
- Write:
  - At a rising clk edge with rst_n=1 and store=1, mem[data_memory_address] <= data_memory_data_in.
  - store=0 leaves the array unchanged.
  - Latency: 1 edge.
- Read:
  - Combinational. data_memory_data_out = mem[data_memory_address] when load=1 and rst_n=1, else 0.
  - No clock latency: an address change is reflected in the same cycle.
- Read-during-write (load=1, store=1, same address):
  - Before the edge, out shows the old contents.
  - After the edge, out shows the newly written word.
  - No internal bypass beyond this array-through behaviour.
- Boundaries:
  - Address 0 and 4095 (0xFFF) are valid. No wrap logic is needed, because the address width exactly covers the depth.
  - Writes to one address never disturb any other address.
- Unknown (X) on store or load is treated as no operation for writes. Verification does not rely on it.
- Output reset value: 0.
- Uninitialised-after-power-up contents are undefined until the first rst_n assertion. The bench applies reset first.

Test Plan:
- Reset: hold rst_n=0, load=1, address=123 -> out=0; release reset, load=1 at addresses 0, 123 and 0xFFF -> each returns 0.
- Load gating: address=123, data_in=0x1234CDEF, store=0, load=0 for several edges -> out=0. Then load=1 -> out=0 (nothing written yet).
- Write then read:
  - Address=123, data_in=0x1234CDEF, store=1 for one edge.
  - With load=0 -> out=0.
  - Raise load=1 -> out=0x1234CDEF in the same cycle.
- Top address with simultaneous load and store:
  - Address=0xFFF, data_in=0xFFFFFFFF, store=1, load=1.
  - Before the edge -> out=0x00000000. After the edge -> out=0xFFFFFFFF.
  - Address back to 123 -> out=0x1234CDEF (word 123 is undisturbed).
- Reset mid-operation: after the writes above, pulse rst_n low between edges -> out drops to 0 immediately. Afterwards, reads of 123 and 0xFFF return 0.
- Overwrite and isolation: write 0xA5A5A5A5 to 0, then 0x5A5A5A5A to 1 -> reading 0 gives 0xA5A5A5A5 and reading 1 gives 0x5A5A5A5A. Rewriting address 0 with 0x00000001 -> reads 0x00000001.

Source files
------------

// File: rtl/data_ram.sv
// Word-addressed data memory for the MEM stage of the RV32I pipeline.
// Full-word synchronous writes, combinational reads gated by load, and an
// asynchronous active-low reset that clears every word.
module data_ram #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] data_memory_address,
    input  logic [DATA_WIDTH-1:0] data_memory_data_in,
    input  logic                  store,
    input  logic                  load,
    output logic [DATA_WIDTH-1:0] data_memory_data_out
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic                  wr_en_d;
    logic [ADDR_WIDTH-1:0] wr_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_d;

    // Write request decode; an unknown store is treated as no write.
    always_comb begin
        wr_en_d   = 1'b0;
        wr_addr_d = data_memory_address;
        wr_data_d = data_memory_data_in;
        if (store == 1'b1) begin
            wr_en_d = 1'b1;
        end
    end

    // Storage array: cleared while reset is low, otherwise one word per edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en_d) begin
            mem_q[wr_addr_d] <= wr_data_d;
        end
    end

    // Combinational read; the output is forced to zero while reset or not loading.
    always_comb begin
        data_memory_data_out = '0;
        if (load && rst_n) begin
            data_memory_data_out = mem_q[data_memory_address];
        end
    end

endmodule

// File: tb/tb_data_ram.sv
// Directed self-checking bench for data_ram.
module tb_data_ram;

    logic        clk;
    logic        rst_n;
    logic [11:0] addr;
    logic [31:0] din;
    logic        store;
    logic        load;
    logic [31:0] dout;

    int checks   = 0;
    int failures = 0;

    data_ram #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .data_memory_address  (addr),
        .data_memory_data_in  (din),
        .store                (store),
        .load                 (load),
        .data_memory_data_out (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just past the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational read settle, then compare.
    task automatic check(input string tag, input logic [31:0] expected);
        #1;
        checks++;
        assert (dout === expected)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, dout, expected);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        load  = 1'b1;
        store = 1'b1;
        addr  = 12'd123;
        din   = 32'hDEAD_BEEF;

        // Reset held: writes ignored, output forced to zero.
        tick();
        tick();
        check("reset_hold_out", 32'h0);

        rst_n = 1'b1;
        store = 1'b0;
        tick();
        addr = 12'd0;
        check("post_reset_addr0", 32'h0);
        addr = 12'd123;
        check("post_reset_addr123", 32'h0);
        addr = 12'hFFF;
        check("post_reset_addrfff", 32'h0);

        // Load gating with nothing written.
        addr = 12'd123;
        din  = 32'h1234_CDEF;
        load = 1'b0;
        tick();
        tick();
        tick();
        check("gate_load0", 32'h0);
        load = 1'b1;
        check("gate_load1_empty", 32'h0);

        // Write then read.
        load  = 1'b0;
        store = 1'b1;
        tick();
        store = 1'b0;
        check("write_load0", 32'h0);
        load = 1'b1;
        check("write_read123", 32'h1234_CDEF);

        // Top address, simultaneous load and store.
        addr  = 12'hFFF;
        din   = 32'hFFFF_FFFF;
        store = 1'b1;
        load  = 1'b1;
        check("rdw_before_edge", 32'h0);
        tick();
        store = 1'b0;
        check("rdw_after_edge", 32'hFFFF_FFFF);
        addr = 12'd123;
        check("isolation_123", 32'h1234_CDEF);

        // Reset pulse between edges with a pending write.
        store = 1'b1;
        din   = 32'hCAFE_F00D;
        #1;
        rst_n = 1'b0;
        check("midreset_out", 32'h0);
        rst_n = 1'b1;
        store = 1'b0;
        check("after_reset_123", 32'h0);
        addr = 12'hFFF;
        check("after_reset_fff", 32'h0);
        tick();
        addr = 12'd123;
        check("after_edge_123", 32'h0);

        // Overwrite and isolation at low addresses.
        addr  = 12'd0;
        din   = 32'hA5A5_A5A5;
        store = 1'b1;
        tick();
        addr = 12'd1;
        din  = 32'h5A5A_5A5A;
        tick();
        store = 1'b0;
        addr  = 12'd0;
        check("iso_read0", 32'hA5A5_A5A5);
        addr = 12'd1;
        check("iso_read1", 32'h5A5A_5A5A);
        addr  = 12'd0;
        din   = 32'h0000_0001;
        store = 1'b1;
        tick();
        store = 1'b0;
        check("overwrite0", 32'h0000_0001);
        addr = 12'd1;
        check("overwrite_keep1", 32'h5A5A_5A5A);
        addr = 12'd2;
        check("untouched2", 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
